ahb_apb4_bridge_mux: RTL and testbench

Parametrised AHB-lite slave to APB4 master bridge serving NUM_SLV APB slaves. The next generation of the single-slave bridge: it adds address decode to per-slave PSEL, PSTRB/PPROT generation, a two-cycle AHB ERROR response, decode and oversize errors, and an APB wait-state timeout. It sits between the AHB interconnect and the peripheral APB segment.

---
 rtl/ahb_apb_pkg.sv | 33 +++
 rtl/apb_slave_mux.sv | 32 +++
 rtl/ahb_apb4_bridge_mux.sv | 138 +++++++++++++
 tb/tb_ahb_apb4_bridge_mux.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_apb_pkg.sv
// Shared types and helpers for the AHB-lite to APB4 bridge.
// Holds the FSM state encoding, AHB code points and the byte-strobe generator.
package ahb_apb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_ERR1,
        ST_ERR2
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Strobes for up to 64-bit buses; the caller truncates to its lane count.
    // The start lane is aligned down to the transfer size.
    function automatic logic [7:0] strb_gen(input logic [2:0] size, input logic [2:0] addr_lsbs);
        logic [3:0]  nbytes;
        logic [2:0]  base;
        logic [15:0] mask;
        nbytes = 4'd1 << size;
        base   = addr_lsbs & ~3'(nbytes - 4'd1);
        mask   = (16'd1 << nbytes) - 16'd1;
        return 8'(mask << base);
    endfunction

endpackage

// File: rtl/apb_slave_mux.sv
// Selects the addressed APB slave's PRDATA/PREADY/PSLVERR by registered index.
// Unselected slaves' responses never reach the bridge FSM.
module apb_slave_mux
    import ahb_apb_pkg::*;
#(
    parameter int NUM_SLV = 4,
    parameter int DATA_W  = 32,
    parameter int IDX_W   = 2
) (
    input  logic [IDX_W-1:0]          idx,
    input  logic [NUM_SLV*DATA_W-1:0] prdata,
    input  logic [NUM_SLV-1:0]        pready,
    input  logic [NUM_SLV-1:0]        pslverr,
    output logic [DATA_W-1:0]         rdata,
    output logic                      ready,
    output logic                      slverr
);

    always_comb begin
        rdata  = '0;
        ready  = 1'b0;
        slverr = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (idx == IDX_W'(i)) begin
                rdata  = prdata[i*DATA_W +: DATA_W];
                ready  = pready[i];
                slverr = pslverr[i];
            end
        end
    end

endmodule

// File: rtl/ahb_apb4_bridge_mux.sv
// AHB-lite slave to APB4 master bridge fanning out to NUM_SLV APB slaves.
// Adds address decode, PSTRB/PPROT, two-cycle ERROR responses and an ACCESS timeout.
module ahb_apb4_bridge_mux
    import ahb_apb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4,
    parameter int SLV_LSB = 12,
    parameter int TIMEOUT = 255
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      HSEL,
    input  logic [ADDR_W-1:0]         HADDR,
    input  logic [1:0]                HTRANS,
    input  logic                      HWRITE,
    input  logic [2:0]                HSIZE,
    input  logic [3:0]                HPROT,
    input  logic [DATA_W-1:0]         HWDATA,
    input  logic                      HREADY,
    output logic                      HREADYOUT,
    output logic                      HRESP,
    output logic [DATA_W-1:0]         HRDATA,
    output logic [NUM_SLV-1:0]        PSEL,
    output logic                      PENABLE,
    output logic [ADDR_W-1:0]         PADDR,
    output logic                      PWRITE,
    output logic [DATA_W-1:0]         PWDATA,
    output logic [DATA_W/8-1:0]       PSTRB,
    output logic [2:0]                PPROT,
    input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLV-1:0]        PREADY,
    input  logic [NUM_SLV-1:0]        PSLVERR
);

    localparam int BW    = DATA_W / 8;
    localparam int LSB_W = $clog2(BW);
    localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [63:0]      ADDR_LIMIT = 64'(NUM_SLV) << SLV_LSB;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx, idx_in, idx_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               accept, bad_addr, bad_size, load_rdata;
    logic [DATA_W-1:0]  sel_rdata;
    logic               sel_ready, sel_err;
    logic               unused_ok;

    assign unused_ok = ^{HTRANS[0], HPROT[3:2]};

    // The AHB data phase is held by HREADYOUT=0 for the whole APB transfer.
    assign PWDATA = HWDATA;

    assign accept   = HSEL && HREADY && HTRANS[1] && (state == ST_IDLE || state == ST_ERR2);
    assign bad_addr = 64'(HADDR) >= ADDR_LIMIT;
    assign bad_size = (32'd8 << HSIZE) > 32'(DATA_W);
    assign idx_in   = HADDR[SLV_LSB +: IDX_W];
    assign idx_nxt  = accept ? idx_in : idx;

    apb_slave_mux #(
        .NUM_SLV (NUM_SLV),
        .DATA_W  (DATA_W),
        .IDX_W   (IDX_W)
    ) u_mux (
        .idx     (idx),
        .prdata  (PRDATA),
        .pready  (PREADY),
        .pslverr (PSLVERR),
        .rdata   (sel_rdata),
        .ready   (sel_ready),
        .slverr  (sel_err)
    );

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        load_rdata = 1'b0;
        unique case (state)
            ST_IDLE, ST_ERR2: begin
                if (accept) state_nxt = (bad_addr || bad_size) ? ST_ERR1 : ST_SETUP;
                else        state_nxt = ST_IDLE;
            end
            ST_SETUP: begin
                state_nxt = ST_ACCESS;
                cnt_nxt   = '0;
            end
            ST_ACCESS: begin
                if (sel_ready) begin
                    state_nxt  = sel_err ? ST_ERR1 : ST_IDLE;
                    load_rdata = !sel_err && !PWRITE;
                end else if (TIMEOUT != 0 && cnt == TO_LAST) begin
                    state_nxt = ST_ERR1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_ERR1: state_nxt = ST_ERR2;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            idx       <= '0;
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
            HRDATA    <= '0;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PSTRB     <= '0;
            PPROT     <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            HREADYOUT <= !(state_nxt inside {ST_SETUP, ST_ACCESS, ST_ERR1});
            HRESP     <= (state_nxt inside {ST_ERR1, ST_ERR2}) ? HRESP_ERROR : HRESP_OKAY;
            PENABLE   <= (state_nxt == ST_ACCESS);
            PSEL      <= (state_nxt inside {ST_SETUP, ST_ACCESS}) ? (NUM_SLV'(1) << idx_nxt) : '0;
            if (accept) begin
                idx    <= idx_in;
                PADDR  <= HADDR;
                PWRITE <= HWRITE;
                PSTRB  <= HWRITE ? BW'(strb_gen(HSIZE, 3'(HADDR[LSB_W-1:0]))) : '0;
                PPROT  <= {~HPROT[0], 1'b0, HPROT[1]};
            end
            if (load_rdata) HRDATA <= sel_rdata;
        end
    end

endmodule

// File: tb/tb_ahb_apb4_bridge_mux.sv
// Bench for ahb_apb4_bridge_mux: transaction-level model predicts each cycle's outputs,
// directed cases pin literal values, then randomized traffic runs against the model.
module tb_ahb_apb4_bridge_mux;
    import ahb_apb_pkg::*;

    localparam int TO = 4;

    logic         HCLK = 1'b0;
    logic         HRESETn = 1'b0;
    logic         HSEL = 1'b0;
    logic [31:0]  HADDR = '0;
    logic [1:0]   HTRANS = HTRANS_IDLE;
    logic         HWRITE = 1'b0;
    logic [2:0]   HSIZE = '0;
    logic [3:0]   HPROT = '0;
    logic [31:0]  HWDATA = '0;
    logic         HREADY = 1'b1;
    logic         HREADYOUT, HRESP, PENABLE, PWRITE;
    logic [31:0]  HRDATA, PADDR, PWDATA;
    logic [3:0]   PSEL, PSTRB;
    logic [2:0]   PPROT;
    logic [127:0] PRDATA = '0;
    logic [3:0]   PREADY = '0;
    logic [3:0]   PSLVERR = '0;

    always #5 HCLK = ~HCLK;

    ahb_apb4_bridge_mux #(
        .ADDR_W(32), .DATA_W(32), .NUM_SLV(4), .SLV_LSB(12), .TIMEOUT(TO)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HPROT(HPROT), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .PSEL(PSEL), .PENABLE(PENABLE),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    int checks = 0;
    int errors = 0;

    // Model expectations for the current cycle
    logic        exp_vld = 1'b0;
    logic        e_hrdy, e_hresp, e_pen, e_pwrite;
    logic [3:0]  e_psel, e_pstrb;
    logic [2:0]  e_pprot;
    logic [31:0] e_paddr, e_pwdata;
    logic [31:0] m_hrdata = '0;

    // Observations used by the literal checks
    int          lo_run = 0, last_lo = 0, ps_run = 0, last_ps = 0;
    logic [3:0]  su_psel = '0, su_pstrb = '0;
    logic [31:0] su_paddr = '0;
    logic        psel_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge HCLK) begin
        if (exp_vld) begin
            chk("hreadyout", 32'(HREADYOUT), 32'(e_hrdy));
            chk("hresp", 32'(HRESP), 32'(e_hresp));
            chk("psel", 32'(PSEL), 32'(e_psel));
            chk("penable", 32'(PENABLE), 32'(e_pen));
            chk("hrdata", HRDATA, m_hrdata);
            if (e_psel != 4'd0) begin
                chk("paddr", PADDR, e_paddr);
                chk("pwrite", 32'(PWRITE), 32'(e_pwrite));
                chk("pstrb", 32'(PSTRB), 32'(e_pstrb));
                chk("pprot", 32'(PPROT), 32'(e_pprot));
                chk("pwdata", PWDATA, e_pwdata);
            end
        end
        if (!HREADYOUT) lo_run++;
        else if (lo_run != 0) begin last_lo = lo_run; lo_run = 0; end
        if (PSEL != 4'd0) begin ps_run++; psel_seen = 1'b1; end
        else if (ps_run != 0) begin last_ps = ps_run; ps_run = 0; end
        if (PSEL != 4'd0 && !PENABLE) begin su_psel = PSEL; su_paddr = PADDR; su_pstrb = PSTRB; end
    end

    // Advance to the next cycle; slaves and the pipelined AHB address are randomized.
    task automatic step();
        @(posedge HCLK);
        #1;
        PREADY  = 4'($urandom);
        PSLVERR = 4'($urandom);
        for (int i = 0; i < 4; i++) PRDATA[i*32 +: 32] = $urandom;
        HSEL   = 1'($urandom);
        HTRANS = 2'($urandom);
        HADDR  = $urandom;
        HWRITE = 1'($urandom);
        HSIZE  = 3'($urandom);
        HPROT  = 4'($urandom);
    endtask

    task automatic set_exp(input logic hrdy, input logic hresp, input logic [3:0] psel, input logic pen);
        e_hrdy  = hrdy;
        e_hresp = hresp;
        e_psel  = psel;
        e_pen   = pen;
        HREADY  = hrdy;
        if (hrdy) HTRANS = HTRANS_IDLE;
    endtask

    task automatic end_cyc();
        @(negedge HCLK);
        #1;
    endtask

    task automatic idle_cycle();
        int r;
        r = $urandom_range(0, 2);
        HSEL   = (r != 0);
        HTRANS = (r == 0) ? 2'($urandom) : (r == 1) ? HTRANS_IDLE : HTRANS_BUSY;
        HADDR  = $urandom_range(0, 32'h3FFF);
        step();
        set_exp(1'b1, 1'b0, 4'd0, 1'b0);
    endtask

    // One AHB transfer: address phase in the current cycle, returns in its last data-phase cycle.
    task automatic do_xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                           input logic [3:0] prot, input logic [31:0] wd, input int waits,
                           input logic err, input logic [31:0] rd, input int rst_k);
        logic bad, to_hit, rdy;
        int   idx, nb, base;
        bad = (addr >= 32'h4000) || ((8 << size) > 32);
        idx = int'(addr[13:12]);
        nb  = 1 << size;
        base = (int'(addr % 4) / nb) * nb;
        e_pstrb = '0;
        for (int b = 0; b < 4; b++) if (wr && b >= base && b < base + nb) e_pstrb[b] = 1'b1;
        e_paddr  = addr;
        e_pwrite = wr;
        e_pprot  = {~prot[0], 1'b0, prot[1]};
        e_pwdata = wd;
        to_hit   = 1'b0;

        HSEL = 1'b1; HADDR = addr; HTRANS = $urandom_range(0, 1) ? HTRANS_NONSEQ : HTRANS_SEQ;
        HWRITE = wr; HSIZE = size; HPROT = prot; HREADY = 1'b1;
        step();
        HWDATA = wd;
        if (bad) begin
            set_exp(1'b0, 1'b1, 4'd0, 1'b0);
            step();
            set_exp(1'b1, 1'b1, 4'd0, 1'b0);
            return;
        end
        set_exp(1'b0, 1'b0, 4'b1 << idx, 1'b0);
        for (int k = 0; k < TO; k++) begin
            step();
            set_exp(1'b0, 1'b0, 4'b1 << idx, 1'b1);
            rdy = (k >= waits);
            PREADY[idx]  = rdy;
            PSLVERR[idx] = rdy ? err : 1'($urandom);
            PRDATA[idx*32 +: 32] = rdy ? rd : $urandom;
            if (k == rst_k) begin
                #2 HRESETn = 1'b0;
                #1;
                exp_vld = 1'b0;
                m_hrdata = '0;
                chk("rst_psel", 32'(PSEL), 32'd0);
                chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
                chk("rst_penable", 32'(PENABLE), 32'd0);
                chk("rst_hresp", 32'(HRESP), 32'd0);
                chk("rst_paddr", PADDR, 32'd0);
                return;
            end
            if (rdy) break;
            if (k + 1 == TO) to_hit = 1'b1;
        end
        step();
        if (to_hit || err) begin
            set_exp(1'b0, 1'b1, 4'd0, 1'b0);
            step();
            set_exp(1'b1, 1'b1, 4'd0, 1'b0);
        end else begin
            if (!wr) m_hrdata = rd;
            set_exp(1'b1, 1'b0, 4'd0, 1'b0);
        end
    endtask

    initial begin
        repeat (2) @(posedge HCLK);
        #1;
        chk("reset_hreadyout", 32'(HREADYOUT), 32'd1);
        chk("reset_hresp", 32'(HRESP), 32'd0);
        chk("reset_hrdata", HRDATA, 32'd0);
        chk("reset_psel", 32'(PSEL), 32'd0);
        chk("reset_penable", 32'(PENABLE), 32'd0);
        chk("reset_paddr", PADDR, 32'd0);
        chk("reset_pwrite", 32'(PWRITE), 32'd0);
        chk("reset_pstrb", 32'(PSTRB), 32'd0);
        chk("reset_pprot", 32'(PPROT), 32'd0);
        HRESETn = 1'b1;
        set_exp(1'b1, 1'b0, 4'd0, 1'b0);
        exp_vld = 1'b1;

        do_xfer(32'h0000_1004, 1'b1, 3'd2, 4'b0011, 32'hDEADBEEF, 0, 1'b0, 32'h0, -1);
        end_cyc();
        chk("wr_psel", 32'(su_psel), 32'h2);
        chk("wr_paddr", su_paddr, 32'h1004);
        chk("wr_pstrb", 32'(su_pstrb), 32'hF);
        chk("wr_waits", 32'(last_lo), 32'd2);
        chk("wr_hresp", 32'(HRESP), 32'd0);

        do_xfer(32'h0000_2008, 1'b0, 3'd2, 4'b0001, 32'h0, 3, 1'b0, 32'h1234_5678, -1);
        end_cyc();
        chk("rd_waits", 32'(last_lo), 32'd5);
        chk("rd_hrdata", HRDATA, 32'h1234_5678);
        chk("rd_hresp", 32'(HRESP), 32'd0);

        do_xfer(32'h0000_0003, 1'b1, 3'd0, 4'b0000, 32'hA5A5_A5A5, 0, 1'b0, 32'h0, -1);
        end_cyc();
        chk("byte_pstrb", 32'(su_pstrb), 32'b1000);

        do_xfer(32'h0000_0010, 1'b0, 3'd2, 4'b0010, 32'h0, 0, 1'b1, 32'hBAD0_BAD0, -1);
        end_cyc();
        chk("slverr_hresp", 32'(HRESP), 32'd1);
        chk("slverr_hreadyout", 32'(HREADYOUT), 32'd1);
        chk("slverr_hrdata", HRDATA, 32'h1234_5678);
        chk("slverr_waits", 32'(last_lo), 32'd3);

        psel_seen = 1'b0;
        do_xfer(32'h0000_4000, 1'b1, 3'd2, 4'b0000, 32'h1, 0, 1'b0, 32'h0, -1);
        end_cyc();
        chk("decode_no_psel", 32'(psel_seen), 32'd0);
        chk("decode_waits", 32'(last_lo), 32'd1);
        chk("decode_hresp", 32'(HRESP), 32'd1);

        do_xfer(32'h0000_3000, 1'b1, 3'd2, 4'b0000, 32'h55, 20, 1'b0, 32'h0, -1);
        end_cyc();
        chk("timeout_psel_len", 32'(last_ps), 32'd5);
        chk("timeout_waits", 32'(last_lo), 32'd6);
        chk("timeout_hresp", 32'(HRESP), 32'd1);
        do_xfer(32'h0000_3010, 1'b0, 3'd2, 4'b0000, 32'h0, 10, 1'b0, 32'h0, 2);
        chk("err2_accept_paddr", su_paddr, 32'h3010);
        repeat (2) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        set_exp(1'b1, 1'b0, 4'd0, 1'b0);
        exp_vld = 1'b1;

        for (int n = 0; n < 300; n++) begin
            repeat ($urandom_range(0, 2)) idle_cycle();
            do_xfer($urandom_range(0, 32'h4FFF), 1'($urandom), 3'($urandom_range(0, 3)),
                    4'($urandom), $urandom, $urandom_range(0, 6),
                    ($urandom_range(0, 7) == 0), $urandom, -1);
        end
        idle_cycle();
        end_cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
